// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops plus an iterative
// shift-add multiplier and restoring divider behind a valid/ready handshake.
module alu_mc #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_mc__req_valid,
  output logic             alu_mc__req_ready,
  input  logic [4:0]       alu_mc__req_op,
  input  logic             alu_mc__req_signed,
  input  logic [WIDTH-1:0] alu_mc__req_left,
  input  logic [WIDTH-1:0] alu_mc__req_right,
  output logic             alu_mc__resp_valid,
  input  logic             alu_mc__resp_ready,
  output logic [WIDTH-1:0] alu_mc__resp_data,
  output logic             alu_mc__resp_cond,
  output logic             alu_mc__resp_err
);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [4:0] ALU_LEFT     = 5'd0;
  localparam logic [4:0] ALU_RIGHT    = 5'd1;
  localparam logic [4:0] ALU_BITOR    = 5'd2;
  localparam logic [4:0] ALU_BITXOR   = 5'd3;
  localparam logic [4:0] ALU_BITAND   = 5'd4;
  localparam logic [4:0] ALU_ADD      = 5'd5;
  localparam logic [4:0] ALU_SUB      = 5'd6;
  localparam logic [4:0] ALU_BITNOT   = 5'd7;
  localparam logic [4:0] ALU_NEG      = 5'd8;
  localparam logic [4:0] ALU_EQ       = 5'd9;
  localparam logic [4:0] ALU_NE       = 5'd10;
  localparam logic [4:0] ALU_LEFT_EQZ = 5'd11;
  localparam logic [4:0] ALU_LEFT_NEZ = 5'd12;
  localparam logic [4:0] ALU_LT       = 5'd13;
  localparam logic [4:0] ALU_LE       = 5'd14;
  localparam logic [4:0] ALU_GT       = 5'd15;
  localparam logic [4:0] ALU_GE       = 5'd16;
  localparam logic [4:0] ALU_NOT      = 5'd17;
  localparam logic [4:0] ALU_LSH      = 5'd18;
  localparam logic [4:0] ALU_RSH      = 5'd19;
  localparam logic [4:0] ALU_URSH     = 5'd20;
  localparam logic [4:0] ALU_MUL      = 5'd27;
  localparam logic [4:0] ALU_DIV      = 5'd28;
  localparam logic [4:0] ALU_DIVU     = 5'd29;
  localparam logic [4:0] ALU_REM      = 5'd30;
  localparam logic [4:0] ALU_REMU     = 5'd31;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              is_mul, is_mul_n, is_rem, is_rem_n;
  logic              neg_q, neg_q_n, neg_r, neg_r_n;
  // acc: product/remainder, dvs: multiplicand/divisor, shr: multiplier/quotient
  logic [WIDTH-1:0]  acc, acc_n, dvs, dvs_n, shr, shr_n;
  logic              resp_valid_n, resp_err_n;
  logic [WIDTH-1:0]  resp_data_n;

  logic [WIDTH-1:0]  l, r, sc_data, labs, rabs, acc_s, dvs_s, shr_s, fin;
  logic signed [WIDTH-1:0] sra;
  logic [SW-1:0]     sh;
  logic [WIDTH:0]    rem_sh, diff;
  logic              sc_err, big, lt, eq, accept, md_op, md_sgn, lneg, rneg;

  assign l      = alu_mc__req_left;
  assign r      = alu_mc__req_right;
  assign sh     = r[SW-1:0];
  assign big    = r >= WIDTH'(WIDTH);
  assign sra    = $signed(l) >>> sh;
  assign eq     = l == r;
  assign lt     = alu_mc__req_signed ? ($signed(l) < $signed(r)) : (l < r);
  assign md_op  = alu_mc__req_op inside {ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign md_sgn = (alu_mc__req_op == ALU_DIV) || (alu_mc__req_op == ALU_REM);
  assign lneg   = md_sgn && l[WIDTH-1];
  assign rneg   = md_sgn && r[WIDTH-1];
  assign labs   = lneg ? -l : l;
  assign rabs   = rneg ? -r : r;

  assign alu_mc__req_ready = (state == IDLE) || (state == DONE && alu_mc__resp_ready);
  assign accept            = alu_mc__req_valid && alu_mc__req_ready;

  // Single-cycle result for the current request
  always_comb begin
    sc_data = '0;
    sc_err  = 1'b0;
    case (alu_mc__req_op)
      ALU_LEFT:     sc_data = l;
      ALU_RIGHT:    sc_data = r;
      ALU_BITOR:    sc_data = l | r;
      ALU_BITXOR:   sc_data = l ^ r;
      ALU_BITAND:   sc_data = l & r;
      ALU_ADD:      sc_data = l + r;
      ALU_SUB:      sc_data = l - r;
      ALU_BITNOT:   sc_data = ~l;
      ALU_NEG:      sc_data = -l;
      ALU_EQ:       sc_data = WIDTH'(eq);
      ALU_NE:       sc_data = WIDTH'(!eq);
      ALU_LEFT_EQZ: sc_data = WIDTH'(l == '0);
      ALU_LEFT_NEZ: sc_data = WIDTH'(l != '0);
      ALU_LT:       sc_data = WIDTH'(lt);
      ALU_LE:       sc_data = WIDTH'(lt || eq);
      ALU_GT:       sc_data = WIDTH'(!(lt || eq));
      ALU_GE:       sc_data = WIDTH'(!lt);
      ALU_NOT:      sc_data = WIDTH'(l == '0);
      ALU_LSH:      sc_data = big ? '0 : (l << sh);
      ALU_RSH:      sc_data = big ? {WIDTH{l[WIDTH-1]}} : $unsigned(sra);
      ALU_URSH:     sc_data = big ? '0 : (l >> sh);
      default:      sc_err  = 1'b1;
    endcase
  end

  // One multiply or restoring-divide step, with sign fix-up of the stepped value
  always_comb begin
    rem_sh = {acc, shr[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    dvs_s  = dvs;
    if (is_mul) begin
      acc_s = shr[0] ? acc + dvs : acc;
      dvs_s = dvs << 1;
      shr_s = shr >> 1;
    end else if (!diff[WIDTH]) begin
      acc_s = diff[WIDTH-1:0];
      shr_s = {shr[WIDTH-2:0], 1'b1};
    end else begin
      acc_s = rem_sh[WIDTH-1:0];
      shr_s = {shr[WIDTH-2:0], 1'b0};
    end
    if (is_mul)      fin = acc_s;
    else if (is_rem) fin = neg_r ? -acc_s : acc_s;
    else             fin = neg_q ? -shr_s : shr_s;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    is_mul_n     = is_mul;
    is_rem_n     = is_rem;
    neg_q_n      = neg_q;
    neg_r_n      = neg_r;
    acc_n        = acc;
    dvs_n        = dvs;
    shr_n        = shr;
    resp_valid_n = alu_mc__resp_valid;
    resp_data_n  = alu_mc__resp_data;
    resp_err_n   = alu_mc__resp_err;
    case (state)
      CALC: begin
        acc_n = acc_s;
        dvs_n = dvs_s;
        shr_n = shr_s;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n      = DONE;
          resp_valid_n = 1'b1;
          resp_data_n  = fin;
          resp_err_n   = 1'b0;
        end
      end
      DONE: begin
        if (alu_mc__resp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      if (md_op && MULDIV_EN) begin
        state_n      = CALC;
        cnt_n        = CW'(WIDTH);
        resp_valid_n = 1'b0;
        is_mul_n     = alu_mc__req_op == ALU_MUL;
        is_rem_n     = (alu_mc__req_op == ALU_REM) || (alu_mc__req_op == ALU_REMU);
        neg_q_n      = (lneg ^ rneg) && (r != '0);
        neg_r_n      = lneg;
        acc_n        = '0;
        dvs_n        = is_mul_n ? l : rabs;
        shr_n        = is_mul_n ? r : labs;
      end else begin
        state_n      = DONE;
        resp_valid_n = 1'b1;
        resp_data_n  = sc_data;
        resp_err_n   = sc_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      is_mul             <= 1'b0;
      is_rem             <= 1'b0;
      neg_q              <= 1'b0;
      neg_r              <= 1'b0;
      acc                <= '0;
      dvs                <= '0;
      shr                <= '0;
      alu_mc__resp_valid <= 1'b0;
      alu_mc__resp_data  <= '0;
      alu_mc__resp_cond  <= 1'b0;
      alu_mc__resp_err   <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      is_mul             <= is_mul_n;
      is_rem             <= is_rem_n;
      neg_q              <= neg_q_n;
      neg_r              <= neg_r_n;
      acc                <= acc_n;
      dvs                <= dvs_n;
      shr                <= shr_n;
      alu_mc__resp_valid <= resp_valid_n;
      alu_mc__resp_data  <= resp_data_n;
      alu_mc__resp_cond  <= resp_data_n[0];
      alu_mc__resp_err   <= resp_err_n;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: three instances (32-bit, 16-bit without mul/div,
// 8-bit), directed vectors pushed at accept, checked by a negedge monitor.
module tb_alu_mc;
  typedef struct {
    logic [63:0] data;
    logic        err;
    int          acc;
    int          lat;
    int          id;
  } exp_t;

  localparam logic [4:0] OP_BITXOR = 5'd3,  OP_ADD = 5'd5,  OP_SUB = 5'd6,  OP_NEG = 5'd8;
  localparam logic [4:0] OP_EQ = 5'd9, OP_LEFT_NEZ = 5'd12, OP_LT = 5'd13, OP_GT = 5'd15;
  localparam logic [4:0] OP_GE = 5'd16, OP_NOT = 5'd17, OP_LSH = 5'd18, OP_RSH = 5'd19;
  localparam logic [4:0] OP_URSH = 5'd20, OP_UNDEF = 5'd25, OP_MUL = 5'd27, OP_DIV = 5'd28;
  localparam logic [4:0] OP_DIVU = 5'd29, OP_REM = 5'd30, OP_REMU = 5'd31;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [3];
  logic [4:0]  req_op [3];
  logic        req_signed [3];
  logic [63:0] req_left [3];
  logic [63:0] req_right [3];
  logic        resp_ready [3];
  logic        req_ready [3];
  logic        resp_valid [3];
  logic [63:0] resp_data [3];
  logic        resp_cond [3];
  logic        resp_err [3];

  logic        rdy0, rdy1, rdy2, val0, val1, val2, cnd0, cnd1, cnd2, err0, err1, err2;
  logic [31:0] dat0;
  logic [15:0] dat1;
  logic [7:0]  dat2;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  exp_t sb [3][$];
  bit seen [3];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc #(.WIDTH(32), .MULDIV_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst),
    .alu_mc__req_valid(req_valid[0]), .alu_mc__req_ready(rdy0),
    .alu_mc__req_op(req_op[0]), .alu_mc__req_signed(req_signed[0]),
    .alu_mc__req_left(req_left[0][31:0]), .alu_mc__req_right(req_right[0][31:0]),
    .alu_mc__resp_valid(val0), .alu_mc__resp_ready(resp_ready[0]),
    .alu_mc__resp_data(dat0), .alu_mc__resp_cond(cnd0), .alu_mc__resp_err(err0));

  alu_mc #(.WIDTH(16), .MULDIV_EN(1'b0)) dut16 (
    .clk(clk), .rst(rst),
    .alu_mc__req_valid(req_valid[1]), .alu_mc__req_ready(rdy1),
    .alu_mc__req_op(req_op[1]), .alu_mc__req_signed(req_signed[1]),
    .alu_mc__req_left(req_left[1][15:0]), .alu_mc__req_right(req_right[1][15:0]),
    .alu_mc__resp_valid(val1), .alu_mc__resp_ready(resp_ready[1]),
    .alu_mc__resp_data(dat1), .alu_mc__resp_cond(cnd1), .alu_mc__resp_err(err1));

  alu_mc #(.WIDTH(8), .MULDIV_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst),
    .alu_mc__req_valid(req_valid[2]), .alu_mc__req_ready(rdy2),
    .alu_mc__req_op(req_op[2]), .alu_mc__req_signed(req_signed[2]),
    .alu_mc__req_left(req_left[2][7:0]), .alu_mc__req_right(req_right[2][7:0]),
    .alu_mc__resp_valid(val2), .alu_mc__resp_ready(resp_ready[2]),
    .alu_mc__resp_data(dat2), .alu_mc__resp_cond(cnd2), .alu_mc__resp_err(err2));

  assign req_ready[0]  = rdy0;
  assign req_ready[1]  = rdy1;
  assign req_ready[2]  = rdy2;
  assign resp_valid[0] = val0;
  assign resp_valid[1] = val1;
  assign resp_valid[2] = val2;
  assign resp_data[0]  = 64'(dat0);
  assign resp_data[1]  = 64'(dat1);
  assign resp_data[2]  = 64'(dat2);
  assign resp_cond[0]  = cnd0;
  assign resp_cond[1]  = cnd1;
  assign resp_cond[2]  = cnd2;
  assign resp_err[0]   = err0;
  assign resp_err[1]   = err1;
  assign resp_err[2]   = err2;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Monitor: latency on first sighting, data/err/cond every presented cycle, pop on drain
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst && resp_valid[i]) begin
        if (sb[i].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp inst%0d: got data %h, required no response", i, resp_data[i]);
        end else begin
          mon_e = sb[i][0];
          if (!seen[i])
            chk($sformatf("latency id%0d", mon_e.id), 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          seen[i] = 1'b1;
          chk($sformatf("data id%0d", mon_e.id), resp_data[i], mon_e.data);
          chk($sformatf("err id%0d", mon_e.id), 64'(resp_err[i]), 64'(mon_e.err));
          chk($sformatf("cond id%0d", mon_e.id), 64'(resp_cond[i]), 64'(mon_e.data[0]));
          if (resp_ready[i]) begin
            void'(sb[i].pop_front());
            seen[i] = 1'b0;
          end
        end
      end
    end
  end

  // Called at posedge+1; holds the request until accepted, then records the expectation
  task automatic issue(input int i, input logic [4:0] op, input logic sgn,
                       input logic [63:0] l, input logic [63:0] r,
                       input logic [63:0] ed, input logic ee, input int lat,
                       input int id, output int waits);
    bit ok;
    exp_t e;
    ok = 1'b0;
    waits = 0;
    req_valid[i]  = 1'b1;
    req_op[i]     = op;
    req_signed[i] = sgn;
    req_left[i]   = l;
    req_right[i]  = r;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
      else begin
        waits++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout id%0d: req_ready stayed 0, required 1", id);
    end else begin
      e.data = ed;
      e.err  = ee;
      e.acc  = cyc;
      e.lat  = lat;
      e.id   = id;
      sb[i].push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int k;
    k = 0;
    while (sb[i].size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sb[i].size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout inst%0d: %0d responses outstanding, required 0", i, sb[i].size());
      sb[i].delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i]  = 1'b0;
      req_op[i]     = '0;
      req_signed[i] = 1'b0;
      req_left[i]   = '0;
      req_right[i]  = '0;
      resp_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 64'(resp_valid[0]), 64'd0);
    chk("reset_req_ready", 64'(req_ready[0]), 64'd1);
    chk("reset_data", resp_data[0], 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle stream
    issue(0, OP_ADD, 1'b0, 64'hFFFFFFFF, 64'd1, 64'd0, 1'b0, 1, 1, w);
    issue(0, OP_SUB, 1'b0, 64'd0, 64'd1, 64'hFFFFFFFF, 1'b0, 1, 2, w);
    chk("stream_waits_sub", 64'(w), 64'd0);
    issue(0, OP_RSH, 1'b0, 64'h80000000, 64'd4, 64'hF8000000, 1'b0, 1, 3, w);
    chk("stream_waits_rsh", 64'(w), 64'd0);

    // Compares, shift boundaries and assorted single-cycle ops
    issue(0, OP_LT, 1'b1, 64'hFFFFFFFF, 64'd1, 64'd1, 1'b0, 1, 4, w);
    issue(0, OP_LT, 1'b0, 64'hFFFFFFFF, 64'd1, 64'd0, 1'b0, 1, 5, w);
    issue(0, OP_URSH, 1'b0, 64'h12345678, 64'd40, 64'd0, 1'b0, 1, 6, w);
    issue(0, OP_RSH, 1'b0, 64'h80000000, 64'd40, 64'hFFFFFFFF, 1'b0, 1, 7, w);
    issue(0, OP_LSH, 1'b0, 64'd1, 64'd31, 64'h80000000, 1'b0, 1, 8, w);
    issue(0, OP_LSH, 1'b0, 64'd1, 64'd32, 64'd0, 1'b0, 1, 9, w);
    issue(0, OP_GE, 1'b1, 64'h80000000, 64'h7FFFFFFF, 64'd0, 1'b0, 1, 10, w);
    issue(0, OP_GT, 1'b0, 64'h80000000, 64'h7FFFFFFF, 64'd1, 1'b0, 1, 11, w);
    issue(0, OP_NOT, 1'b0, 64'd0, 64'd9, 64'd1, 1'b0, 1, 12, w);
    issue(0, OP_LEFT_NEZ, 1'b0, 64'd5, 64'd0, 64'd1, 1'b0, 1, 13, w);
    issue(0, OP_NEG, 1'b0, 64'd1, 64'd0, 64'hFFFFFFFF, 1'b0, 1, 14, w);
    issue(0, OP_BITXOR, 1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1, 15, w);
    issue(0, OP_UNDEF, 1'b0, 64'd3, 64'd4, 64'd0, 1'b1, 1, 16, w);

    // Iterative mul/div including division boundary cases
    issue(0, OP_MUL, 1'b0, 64'hFFFFFFFF, 64'd3, 64'hFFFFFFFD, 1'b0, 33, 40, w);
    issue(0, OP_DIV, 1'b0, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 1'b0, 33, 41, w);
    issue(0, OP_REM, 1'b0, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 1'b0, 33, 42, w);
    issue(0, OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFF, 1'b0, 33, 43, w);
    issue(0, OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1'b0, 33, 44, w);
    issue(0, OP_DIV, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1'b0, 33, 45, w);
    issue(0, OP_REM, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'd0, 1'b0, 33, 46, w);
    issue(0, OP_REM, 1'b0, 64'hFFFFFFF9, 64'd0, 64'hFFFFFFF9, 1'b0, 33, 47, w);
    issue(0, OP_DIV, 1'b0, 64'd7, 64'd0, 64'hFFFFFFFF, 1'b0, 33, 48, w);
    issue(0, OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 33, 49, w);
    drain(0);

    // Backpressure on a finished MUL, then drain and accept in the same cycle
    resp_ready[0] = 1'b0;
    issue(0, OP_MUL, 1'b0, 64'd6, 64'd7, 64'd42, 1'b0, 33, 50, w);
    for (int k = 0; k < 100 && !resp_valid[0]; k++) @(negedge clk);
    chk("bp_valid", 64'(resp_valid[0]), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_req_ready", 64'(req_ready[0]), 64'd0);
      chk("bp_hold_data", resp_data[0], 64'd42);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready[0] = 1'b1;
    issue(0, OP_EQ, 1'b0, 64'd9, 64'd9, 64'd1, 1'b0, 1, 51, w);
    chk("drain_accept_waits", 64'(w), 64'd0);
    drain(0);

    // Narrow instances: disabled mul/div and 8-bit iterative ops
    issue(1, OP_DIV, 1'b1, 64'd100, 64'd7, 64'd0, 1'b1, 1, 60, w);
    issue(1, OP_ADD, 1'b0, 64'hFFFF, 64'd2, 64'd1, 1'b0, 1, 61, w);
    issue(2, OP_MUL, 1'b0, 64'h10, 64'h10, 64'h00, 1'b0, 9, 70, w);
    issue(2, OP_DIVU, 1'b0, 64'd200, 64'd7, 64'd28, 1'b0, 9, 71, w);
    issue(2, OP_REM, 1'b0, 64'h9C, 64'd7, 64'hFE, 1'b0, 9, 72, w);
    drain(1);
    drain(2);

    // Reset during CALC abandons the DIVU; a later ADD behaves normally
    issue(0, OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 33, 80, w);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb[0].delete();
    seen[0] = 1'b0;
    @(negedge clk);
    chk("rst_calc_valid", 64'(resp_valid[0]), 64'd0);
    chk("rst_calc_req_ready", 64'(req_ready[0]), 64'd1);
    chk("rst_calc_data", resp_data[0], 64'd0);
    chk("rst_calc_err", 64'(resp_err[0]), 64'd0);
    chk("rst_calc_cond", 64'(resp_cond[0]), 64'd0);
    @(posedge clk);
    #1;
    issue(0, OP_ADD, 1'b0, 64'd3, 64'd4, 64'd7, 1'b0, 1, 81, w);
    drain(0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the CPU's combinational ALU. Accepts one operation per request over a valid/ready handshake. Returns every result registered, with a condition bit and an error flag. Adds signed/unsigned compare selection, arithmetic right shift, and iterative multiply/divide/remainder. Sits between the decode/operand-fetch stage and writeback, so the core can stall on long operations.

## Interface
- WIDTH, 32: datapath width. Legal values are 8, 16, 32 and 64.
- MULDIV_EN, 1: enables the iterative unit. When 0, MUL/DIV/DIVU/REM/REMU return resp_err=1 and data 0.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- alu_mc__req_valid  in  1  request present.
- alu_mc__req_ready  out  1  block can accept a request this cycle.
- alu_mc__req_op  in  5  opcode, taken from the shared `ALU_*` defines. New codes: ALU_MUL=5'd27, ALU_DIV=5'd28, ALU_DIVU=5'd29, ALU_REM=5'd30, ALU_REMU=5'd31.
- alu_mc__req_signed  in  1  selects signed interpretation for LT/LE/GT/GE.
- alu_mc__req_left  in  WIDTH  left operand.
- alu_mc__req_right  in  WIDTH  right operand.
- alu_mc__resp_valid  out  1  result present.
- alu_mc__resp_ready  in  1  consumer takes the result.
- alu_mc__resp_data  out  WIDTH  result.
- alu_mc__resp_cond  out  1  equals resp_data[0].
- alu_mc__resp_err  out  1  undefined or disabled opcode.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- **Handshake:**
  - A request is accepted on any cycle with req_valid && req_ready.
  - req_ready = (state==IDLE) || (state==DONE && resp_ready).
  - A result therefore drains and a new request is accepted in the same cycle.
- **Accepting a single-cycle op:** the result is computed and registered, and the FSM goes to DONE.
- **Accepting MUL/DIV/DIVU/REM/REMU:** operands are latched, the iteration counter is loaded with WIDTH, and the FSM goes to CALC.
- **CALC:**
  - One shift-add step (MUL) or one restoring-division step (DIV*) per cycle.
  - The FSM goes to DONE when the counter reaches 0; the sign fix-up is applied on that last step.
- **DONE:**
  - resp_valid=1, and resp_data/cond/err are held stable until resp_ready.
  - On the drain cycle: if a new request is accepted, the FSM follows the accept rules above; otherwise it returns to IDLE.
- **Single-cycle op semantics:**
  - LEFT, RIGHT, BITOR, BITXOR, BITAND, ADD, SUB, BITNOT, NEG: as their names say. ADD/SUB/NEG wrap modulo 2^WIDTH.
  - EQ, NE, LEFT_EQZ, LEFT_NEZ, and LT/LE/GT/GE (signed when req_signed=1) return 1 or 0, zero-extended to WIDTH.
  - NOT is logical NOT: left==0 gives 1.
- **Shifts:**
  - The full right operand is the shift amount.
  - Amount >= WIDTH gives 0 for LSH/URSH and a full copy of the sign bit for RSH.
  - RSH is arithmetic; URSH is logical.
- **MUL:** low WIDTH bits of the product; signedness does not matter.
- **DIV/REM (signed):** the quotient truncates toward zero and the remainder takes the dividend's sign.
- **Division boundary cases:**
  - Divide by zero: quotient = all ones and remainder = left, for all DIV* ops.
  - Signed MIN / -1: quotient = MIN and remainder = 0.
  - resp_err=0 in all of these cases.
- **Undefined opcode, or mul/div with MULDIV_EN=0:** single-cycle, resp_data=0, resp_err=1.
- **Reset:** applies at any time, including during CALC or DONE. The in-flight op is abandoned and the result is never presented. Next cycle: state=IDLE, resp_valid=0, resp_data=0, resp_err=0, resp_cond=0, req_ready=1, counter=0.

## Timing
- Accept edge = edge N.
- **Single-cycle ops:** resp_valid is high from edge N+1 (latency 1).
- **Mul/div ops:** resp_valid is high from edge N+WIDTH+1 (latency WIDTH+1). req_ready is 0 throughout CALC.
- **Throughput:** with resp_ready held at 1, single-cycle ops sustain one per cycle. Mul/div ops sustain one per WIDTH+1 cycles.
- All outputs are driven from registers. req_ready is the exception: it is combinational from state and resp_ready. There is no other input-to-output combinational path.

## Test plan
- **Reset:** assert rst during CALC of a DIVU at WIDTH=32 → next cycle resp_valid=0, req_ready=1, and data/err are 0. A later ADD 3+4 returns 7 one cycle after accept.
- **Single-cycle stream:** back-to-back ADD 0xFFFFFFFF+1, then SUB 0-1, then RSH 0x80000000>>>4, with resp_ready=1 → results 0, 0xFFFFFFFF, 0xF8000000 on consecutive cycles.
- **Signed compare:** LT 0xFFFFFFFF vs 1 → 1 with req_signed=1, and 0 with req_signed=0. URSH by 40 → 0; RSH of 0x80000000 by 40 → 0xFFFFFFFF.
- **Mul/div results:**
  - MUL 0xFFFFFFFF*3 → 0xFFFFFFFD after 33 cycles.
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
- **Backpressure:** hold resp_ready=0 for 5 cycles after a MUL completes → resp_data stable and req_ready=0. Raise resp_ready together with a new EQ request → the EQ is accepted on the drain cycle and its result appears on the next cycle.
- **Errors:** opcode 5'd25 → resp_err=1 and data 0. With MULDIV_EN=0 and WIDTH=16, DIV → resp_err=1 after 1 cycle. WIDTH=8 MUL 0x10*0x10 → 0x00 after 9 cycles.
